// File: rtl/capture_pkt_sched.sv
// Capture packet scheduler: frames a sample stream into packets with a
// leading idle period and inter-packet gaps, drawing words either from a
// first-word-fall-through buffer or from an internal counter pattern.
module capture_pkt_sched #(
    parameter int DW = 18,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          sw_rstn,
    input  logic          clk_en,
    input  logic          capture_start,
    input  logic          self_test_mode,
    input  logic [7:0]    pkt_idle_length,
    input  logic [7:0]    pkt_gap,
    input  logic [CW-1:0] pkt_length,
    input  logic [CW-1:0] pkt_num,
    input  logic          buf_empty,
    input  logic [DW-1:0] buf_rdata,
    output logic          buf_rd_en,
    output logic [DW-1:0] adc_data,
    output logic          adc_data_valid,
    output logic          busy,
    output logic          done,
    output logic          underflow
);

    typedef enum logic [2:0] {IDLE, PRE, SEND, GAP, DONE} state_t;

    state_t        state_reg, state_next;

    // Configuration captured on an accepted start and held for the capture
    logic [7:0]    idle_reg, gap_reg;
    logic [CW-1:0] len_reg, num_reg;
    logic          self_test_reg;

    logic [7:0]    wait_cnt_reg;
    logic [CW-1:0] word_cnt_reg, pkt_cnt_reg;
    logic [DW-1:0] pat_cnt_reg;
    logic [DW-1:0] adc_data_reg;
    logic          adc_valid_reg, done_reg, underflow_reg;

    logic          start_ok, word_avail, emit, last_word, last_pkt, wait_last;
    logic [7:0]    wait_lim_m1;
    logic [DW-1:0] src_data;

    assign start_ok    = (state_reg == IDLE) & capture_start & clk_en;
    assign word_avail  = self_test_reg | ~buf_empty;
    assign emit        = (state_reg == SEND) & word_avail & clk_en;
    // Compare against limit-1 so a full-scale length/count never overflows
    assign last_word   = (word_cnt_reg == (len_reg - CW'(1)));
    assign last_pkt    = (pkt_cnt_reg == (num_reg - CW'(1)));
    assign wait_lim_m1 = ((state_reg == PRE) ? idle_reg : gap_reg) - 8'd1;
    assign wait_last   = (wait_cnt_reg == wait_lim_m1);
    assign src_data    = self_test_reg ? pat_cnt_reg : buf_rdata;

    assign buf_rd_en      = (state_reg == SEND) & ~buf_empty & clk_en & ~self_test_reg;
    assign busy           = (state_reg != IDLE);
    assign adc_data       = adc_data_reg;
    assign adc_data_valid = adc_valid_reg;
    assign done           = done_reg;
    assign underflow      = underflow_reg;

    // State register; soft reset wins over the clock enable
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else if (!sw_rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; nothing advances while clk_en is low
    always_comb begin
        state_next = state_reg;
        if (clk_en) begin
            case (state_reg)
                IDLE: begin
                    if (capture_start) begin
                        if ((pkt_length == '0) || (pkt_num == '0)) begin
                            state_next = DONE;
                        end else if (pkt_idle_length == 8'd0) begin
                            state_next = SEND;
                        end else begin
                            state_next = PRE;
                        end
                    end
                end
                PRE: begin
                    if (wait_last) state_next = SEND;
                end
                SEND: begin
                    if (emit && last_word) begin
                        if (last_pkt) begin
                            state_next = DONE;
                        end else if (gap_reg == 8'd0) begin
                            state_next = SEND;
                        end else begin
                            state_next = GAP;
                        end
                    end
                end
                GAP: begin
                    if (wait_last) state_next = SEND;
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Counters, captured configuration and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_reg      <= '0;
            gap_reg       <= '0;
            len_reg       <= '0;
            num_reg       <= '0;
            self_test_reg <= 1'b0;
            wait_cnt_reg  <= '0;
            word_cnt_reg  <= '0;
            pkt_cnt_reg   <= '0;
            pat_cnt_reg   <= '0;
            adc_data_reg  <= '0;
            adc_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (!sw_rstn) begin
            idle_reg      <= '0;
            gap_reg       <= '0;
            len_reg       <= '0;
            num_reg       <= '0;
            self_test_reg <= 1'b0;
            wait_cnt_reg  <= '0;
            word_cnt_reg  <= '0;
            pkt_cnt_reg   <= '0;
            pat_cnt_reg   <= '0;
            adc_data_reg  <= '0;
            adc_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clk_en) begin
            if (start_ok) begin
                idle_reg      <= pkt_idle_length;
                gap_reg       <= pkt_gap;
                len_reg       <= pkt_length;
                num_reg       <= pkt_num;
                self_test_reg <= self_test_mode;
                wait_cnt_reg  <= '0;
                word_cnt_reg  <= '0;
                pkt_cnt_reg   <= '0;
                pat_cnt_reg   <= '0;
                underflow_reg <= 1'b0;
            end
            // Idle/gap timer restarts at zero each time it expires
            if ((state_reg == PRE) || (state_reg == GAP)) begin
                wait_cnt_reg <= wait_last ? 8'd0 : (wait_cnt_reg + 8'd1);
            end
            if (emit) begin
                word_cnt_reg <= last_word ? '0 : (word_cnt_reg + CW'(1));
                if (last_word) pkt_cnt_reg <= pkt_cnt_reg + CW'(1);
                if (self_test_reg) pat_cnt_reg <= pat_cnt_reg + DW'(1);
                adc_data_reg <= src_data;
            end
            // A stall in buffer mode holds the word counter and flags underflow
            if ((state_reg == SEND) && !self_test_reg && buf_empty) begin
                underflow_reg <= 1'b1;
            end
            adc_valid_reg <= emit;
            done_reg      <= (state_reg == DONE);
        end
    end

endmodule

// File: doc/capture_pkt_sched.md
CAPTURE_PKT_SCHED -- requirements
Module: capture_pkt_sched

Interface
REQ-001 Parameter DW, default 18, ADC sample width driven to the ADC_DATA pads.
REQ-002 Parameter CW, default 16, width of the packet length and packet count fields.
REQ-003 Clocking and reset SHALL be one clock, with reset asynchronous and active-low: ports clk and rstn.
REQ-004 clk  in  1  core clock; all logic SHALL be rising-edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 sw_rstn  in  1  regfile soft reset, synchronous, active-low.
REQ-007 clk_en  in  1  regfile pktctrl_clk_en; low SHALL freeze all state and outputs.
REQ-008 capture_start  in  1  single-cycle start pulse.
REQ-009 self_test_mode  in  1  1 = counter pattern source, 0 = buffer source.
REQ-010 pkt_idle_length  in  8  idle cycles before the first packet.
REQ-011 pkt_gap  in  8  idle cycles between packets.
REQ-012 pkt_length  in  CW  words per packet.
REQ-013 pkt_num  in  CW  packets per capture.
REQ-014 buf_empty  in  1  sample buffer empty (first-word-fall-through).
REQ-015 buf_rdata  in  DW  buffer head word, valid when buf_empty=0.
REQ-016 buf_rd_en  out  1  pop request; the head word SHALL be consumed in the same cycle.
REQ-017 adc_data  out  DW  registered output sample.
REQ-018 adc_data_valid  out  1  registered qualifier for adc_data.
REQ-019 busy  out  1  high while the capture is not in IDLE.
REQ-020 done  out  1  one-cycle pulse at capture end.
REQ-021 underflow  out  1  sticky flag, set when the buffer runs empty during SEND.

Function
REQ-022 The FSM SHALL have states IDLE, PRE, SEND, GAP and DONE; config inputs SHALL be sampled into registers on the start pulse and held for the whole capture.
REQ-023 IDLE -> PRE SHALL occur on capture_start when pkt_length!=0 and pkt_num!=0; PRE SHALL last pkt_idle_length cycles, and 0 SHALL go straight to SEND.
REQ-024 capture_start with pkt_length=0 or pkt_num=0 SHALL go IDLE -> DONE, with no valid words produced.
REQ-025 SEND SHALL emit exactly pkt_length words, popping one word per cycle when a source word is available.
REQ-026 At the end of a packet the FSM SHALL go to GAP if packets remain, otherwise to DONE; GAP SHALL last pkt_gap cycles and then return to SEND, and pkt_gap=0 SHALL give back-to-back packets.
REQ-027 DONE SHALL last one cycle and then go to IDLE.
REQ-028 Latency: with start sampled high at cycle S and no underflow, the first adc_data_valid SHALL occur at S+pkt_idle_length+2.
REQ-029 Latency: if a packet's last valid word is at cycle L, the next packet's first valid word SHALL be at L+pkt_gap+1.
REQ-030 Latency: done SHALL pulse at cycle L+1 after the final valid word at L, and busy SHALL be low from that same cycle.
REQ-031 A popped word SHALL appear on adc_data with adc_data_valid=1 exactly one cycle after the pop.
REQ-032 In cycles without a valid word, adc_data SHALL hold its last value and adc_data_valid SHALL be 0.
REQ-033 Buffer mode: buf_rd_en = (state==SEND) & ~buf_empty & clk_en.
REQ-034 Buffer mode: when buf_empty=1 in SEND, the FSM SHALL stall with the word counter held, set underflow, and resume with no word lost or duplicated.
REQ-035 Self-test mode: buf_rd_en SHALL stay 0, and the source SHALL be a DW-bit counter.
REQ-036 Self-test mode: the counter SHALL be cleared to 0 on an accepted start, increment per emitted word, continue across packets, and wrap from 2^DW-1 to 0.
REQ-037 capture_start while busy SHALL be ignored.
REQ-038 A simultaneous final word and start pulse SHALL leave the start ignored.
REQ-039 Word and packet counters SHALL be CW bits wide; a full-scale value of 2^CW-1 SHALL be supported exactly, with no overflow.
REQ-040 underflow SHALL clear only on rstn, on sw_rstn, or on an accepted capture_start.

Reset
REQ-041 With rstn=0, outputs SHALL be adc_data=0, adc_data_valid=0, buf_rd_en=0, busy=0, done=0, underflow=0, and the state SHALL be IDLE.
REQ-042 With sw_rstn=0 sampled at an edge, the state SHALL be the same as in REQ-041 from the next cycle, including mid-capture; this reset SHALL take effect regardless of clk_en.
REQ-043 Asserting rstn mid-capture SHALL abort immediately, with no done pulse.

Verification
REQ-044 Self-test, idle=15, gap=8, len=4, num=3, start at S -> valid at S+17..S+20, S+29..S+32 and S+41..S+44; data 0..11; done at S+45.
REQ-045 Buffer mode, idle=0, gap=0, len=8, num=2, buffer preloaded with 16 words -> 16 consecutive valid words starting at S+2, matching buffer order; underflow=0.
REQ-046 Buffer mode, len=6, buffer empty for 3 cycles after word 2 -> valid drops for 3 cycles, 6 words total, no duplicates, underflow=1 until the next start.
REQ-047 pkt_num=0, start pulse -> done at S+2, adc_data_valid never high, busy high only for the DONE cycle.
REQ-048 sw_rstn pulse during SEND of packet 2, followed by a new start -> immediate return to IDLE with no done; the restart runs the full sequence with the counter restarting at 0.
REQ-049 clk_en=0 for 5 cycles during GAP -> all outputs frozen; the sequence resumes and the total gap is 8 enabled cycles.
